// File: rtl/dtob_key_encoder.sv
// Decimal-to-binary key encoder.
// Ten raw key lines pass through a two-flop synchronizer. A small FSM then
// debounces both the press and the release. The accepted pattern is
// priority-encoded to a BCD digit, with the highest set bit winning.
// Each accepted press raises a single-cycle valid strobe.
module dtob_key_encoder #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] key,
    output logic [3:0] bcd,
    output logic       valid,
    output logic       multi,
    output logic       held
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_DEBOUNCE = 2'd1;
    localparam logic [1:0] ST_HELD     = 2'd2;
    localparam logic [1:0] ST_RELEASE  = 2'd3;

    localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

    // Index of the highest set bit; 0 for an all-zero pattern.
    function automatic logic [3:0] encode_highest(input logic [9:0] v);
        logic [3:0] r;
        r = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (v[i]) begin
                r = 4'(i);
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    // True when more than one bit is set. Clearing the lowest set bit
    // leaves a nonzero value only if another bit was also set.
    function automatic logic more_than_one(input logic [9:0] v);
        return ((v & (v - 10'd1)) != 10'd0);
    endfunction

    logic [9:0] s1_r;
    logic [9:0] ks_r;
    logic [1:0] state_r;
    logic [9:0] cand_r;
    logic [7:0] cnt_r;
    logic [3:0] bcd_r;
    logic       valid_r;
    logic       multi_r;
    logic       held_r;

    logic [1:0] state_s;
    logic [9:0] cand_s;
    logic [7:0] cnt_s;
    logic       accept_s;

    // Next-state logic for the debounce FSM.
    always_comb begin
        state_s  = state_r;
        cand_s   = cand_r;
        cnt_s    = cnt_r;
        accept_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (ks_r != 10'd0) begin
                    cand_s  = ks_r;
                    cnt_s   = 8'd0;
                    state_s = ST_DEBOUNCE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_DEBOUNCE: begin
                if (ks_r == 10'd0) begin
                    state_s = ST_IDLE;
                end else if (ks_r != cand_r) begin
                    cand_s = ks_r;
                    cnt_s  = 8'd0;
                end else if (cnt_r == CNT_LAST) begin
                    state_s  = ST_HELD;
                    accept_s = 1'b1;
                end else begin
                    cnt_s = cnt_r + 8'd1;
                end
            end
            ST_HELD: begin
                if (ks_r == 10'd0) begin
                    cnt_s   = 8'd0;
                    state_s = ST_RELEASE;
                end else begin
                    state_s = ST_HELD;
                end
            end
            ST_RELEASE: begin
                // A nonzero sample here is treated as release bounce of the
                // same press, so the FSM returns to HELD without a new strobe.
                if (ks_r != 10'd0) begin
                    state_s = ST_HELD;
                end else if (cnt_r == CNT_LAST) begin
                    state_s = ST_IDLE;
                end else begin
                    cnt_s = cnt_r + 8'd1;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cand_s  = 10'd0;
                cnt_s   = 8'd0;
            end
        endcase
    end

    // Two-flop synchronizer on the asynchronous key lines.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_r <= 10'd0;
            ks_r <= 10'd0;
        end else begin
            s1_r <= key;
            ks_r <= s1_r;
        end
    end

    // FSM state, candidate pattern and debounce counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cand_r  <= 10'd0;
            cnt_r   <= 8'd0;
        end else begin
            state_r <= state_s;
            cand_r  <= cand_s;
            cnt_r   <= cnt_s;
        end
    end

    // Registered outputs; bcd and multi change only when a press is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcd_r   <= 4'd0;
            valid_r <= 1'b0;
            multi_r <= 1'b0;
            held_r  <= 1'b0;
        end else begin
            valid_r <= accept_s;
            held_r  <= (state_s == ST_HELD) || (state_s == ST_RELEASE);
            if (accept_s) begin
                bcd_r   <= encode_highest(cand_r);
                multi_r <= more_than_one(cand_r);
            end else begin
                bcd_r   <= bcd_r;
                multi_r <= multi_r;
            end
        end
    end

    assign bcd   = bcd_r;
    assign valid = valid_r;
    assign multi = multi_r;
    assign held  = held_r;

endmodule

// File: tb/tb_dtob_key_encoder.sv
// Self-checking bench for dtob_key_encoder.
// The reference model works on run lengths of the synchronized key value.
// A press is accepted after the same nonzero value has been seen on D+1
// consecutive edges. A release completes after zero has been seen on D+1
// consecutive edges.
module tb_dtob_key_encoder;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] key;
    logic [3:0] bcd;
    logic       valid;
    logic       multi;
    logic       held;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Model state.
    logic [9:0] s1_m, ks_m, run_val;
    int         run_len;
    bit         pressed;
    logic [3:0] bcd_m;
    bit         valid_m, multi_m;

    // Observed valid events, used by the directed literal checks.
    int         valid_cnt;
    int         last_bcd;
    int         last_multi;
    int         last_valid_cyc;

    dtob_key_encoder #(.DEBOUNCE_CYCLES(D)) dut (
        .clk   (clk),
        .rst   (rst),
        .key   (key),
        .bcd   (bcd),
        .valid (valid),
        .multi (multi),
        .held  (held)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] highest_digit(input logic [9:0] v);
        logic [3:0] r;
        r = 4'd0;
        for (int i = 0; i < 10; i++) if (v[i]) r = 4'(i);
        return r;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Cycle counter.
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Behavioural reference model.
    initial begin
        s1_m = 10'd0; ks_m = 10'd0; run_val = 10'd0; run_len = 0;
        pressed = 0; bcd_m = 4'd0; valid_m = 0; multi_m = 0;
        forever begin
            logic [9:0] obs;
            @(posedge clk or posedge rst);
            if (rst) begin
                s1_m = 10'd0; ks_m = 10'd0; run_val = 10'd0; run_len = 0;
                pressed = 0; bcd_m = 4'd0; valid_m = 0; multi_m = 0;
            end else begin
                obs  = ks_m;
                ks_m = s1_m;
                s1_m = key;
                valid_m = 0;
                if (obs == run_val) run_len++;
                else begin
                    run_val = obs;
                    run_len = 1;
                end
                if (!pressed) begin
                    if (obs != 10'd0 && run_len == D + 1) begin
                        pressed = 1;
                        valid_m = 1;
                        bcd_m   = highest_digit(obs);
                        multi_m = ($countones(obs) > 1);
                    end
                end else if (obs == 10'd0 && run_len == D + 1) begin
                    pressed = 0;
                end
            end
        end
    end

    // Per-cycle compare against the model, plus valid-event capture.
    initial begin
        valid_cnt = 0; last_bcd = -1; last_multi = -1; last_valid_cyc = -1;
        forever begin
            @(negedge clk);
            check("bcd",   int'(bcd),   int'(bcd_m));
            check("valid", int'(valid), int'(valid_m));
            check("multi", int'(multi), int'(multi_m));
            check("held",  int'(held),  int'(pressed));
            if (valid) begin
                valid_cnt++;
                last_bcd       = int'(bcd);
                last_multi     = int'(multi);
                last_valid_cyc = cyc;
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    initial begin
        int c;
        rst = 1'b1;
        key = 10'd0;
        wait_cyc(3);
        check("reset_bcd",   int'(bcd),   0);
        check("reset_valid", int'(valid), 0);
        check("reset_held",  int'(held),  0);
        rst = 1'b0;
        wait_cyc(2);

        // 1: single press of digit 3, latency and release timing.
        valid_cnt = 0;
        key = 10'b00_0000_1000;
        c = cyc;
        wait_cyc(20);
        check("t1_valid_cycle", last_valid_cyc, c + 7);
        check("t1_valid_count", valid_cnt, 1);
        check("t1_bcd",         last_bcd, 3);
        check("t1_multi",       last_multi, 0);
        check("t1_held",        int'(held), 1);
        key = 10'd0;
        c = cyc;
        wait_cyc(6);
        check("t1_held_before_fall", int'(held), 1);
        wait_cyc(1);
        check("t1_held_after_fall",  int'(held), 0);
        check("t1_fall_cycle",       cyc, c + 7);
        wait_cyc(4);

        // 2: digits 2 and 7 together, then a lone digit 0.
        valid_cnt = 0;
        key = 10'b00_1000_0100;
        wait_cyc(15);
        check("t2_count_a", valid_cnt, 1);
        check("t2_bcd_a",   last_bcd, 7);
        check("t2_multi_a", last_multi, 1);
        key = 10'd0;
        wait_cyc(10);
        key = 10'b00_0000_0001;
        wait_cyc(15);
        check("t2_count_b", valid_cnt, 2);
        check("t2_bcd_b",   last_bcd, 0);
        check("t2_multi_b", last_multi, 0);
        key = 10'd0;
        wait_cyc(10);

        // 3: press bounce on digit 5.
        valid_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            key = 10'b00_0010_0000;
            wait_cyc(2);
            key = 10'd0;
            wait_cyc(2);
        end
        check("t3_no_valid_bounce", valid_cnt, 0);
        key = 10'b00_0010_0000;
        wait_cyc(15);
        check("t3_count", valid_cnt, 1);
        check("t3_bcd",   last_bcd, 5);
        key = 10'd0;
        wait_cyc(10);

        // 4: release bounce on digit 9.
        valid_cnt = 0;
        key = 10'b10_0000_0000;
        wait_cyc(15);
        key = 10'd0;
        wait_cyc(2);
        check("t4_held_gap", int'(held), 1);
        key = 10'b10_0000_0000;
        wait_cyc(3);
        check("t4_held_restore", int'(held), 1);
        check("t4_bcd_mid",      int'(bcd), 9);
        key = 10'd0;
        wait_cyc(12);
        check("t4_count",    valid_cnt, 1);
        check("t4_bcd",      int'(bcd), 9);
        check("t4_released", int'(held), 0);

        // 5: reset during DEBOUNCE with digit 4 still down.
        valid_cnt = 0;
        key = 10'b00_0001_0000;
        wait_cyc(4);
        rst = 1'b1;
        wait_cyc(1);
        check("t5_rst_bcd",   int'(bcd),   0);
        check("t5_rst_valid", int'(valid), 0);
        check("t5_rst_multi", int'(multi), 0);
        check("t5_rst_held",  int'(held),  0);
        wait_cyc(2);
        check("t5_no_valid_in_rst", valid_cnt, 0);
        rst = 1'b0;
        c = cyc;
        wait_cyc(15);
        check("t5_count",       valid_cnt, 1);
        check("t5_bcd",         last_bcd, 4);
        check("t5_valid_cycle", last_valid_cyc, c + 7);
        key = 10'd0;
        wait_cyc(10);

        // 6: every digit in turn.
        valid_cnt = 0;
        for (int d = 0; d < 10; d++) begin
            key = 10'd1 << d;
            wait_cyc(12);
            check("t6_bcd",   last_bcd, d);
            check("t6_multi", last_multi, 0);
            key = 10'd0;
            wait_cyc(10);
        end
        check("t6_count", valid_cnt, 10);

        // Randomized patterns and durations, with occasional resets.
        for (int n = 0; n < 400; n++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r < 3)      key = 10'd0;
            else if (r < 7) key = 10'd1 << $urandom_range(0, 9);
            else            key = 10'($urandom_range(1, 1023));
            if ($urandom_range(0, 49) == 0) begin
                rst = 1'b1;
                wait_cyc(2);
                rst = 1'b0;
            end
            wait_cyc(int'($urandom_range(1, 10)));
        end
        key = 10'd0;
        wait_cyc(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dtob_key_encoder.md
# dtob_key_encoder

Decimal-to-binary key encoder: the encode-side counterpart of the binary-to-decimal decoder. It takes ten raw active-high decimal key lines (digits 0–9), synchronizes and debounces them, and priority-encodes the accepted key into a 4-bit BCD code. It reports each accepted press exactly once with a single-cycle `valid` strobe. It sits between the front-panel key inputs and any logic that consumes 4-bit digit codes, including the decimal decoder itself.

## Interface
- `DEBOUNCE_CYCLES`, default 4: cycles `key` must stay stable before a press or release is accepted. Legal range 1–255.
- `clk`  in  1  — single system clock; all state updates on the rising edge.
- `rst`  in  1  — asynchronous, active-high reset.
- `key`  in  10  — raw key lines; bit n high means digit n is pressed. Asynchronous to `clk`.
- `bcd`  out  4  — BCD code of the last accepted key, 0–9. Holds its value between presses.
- `valid`  out  1  — one-cycle pulse when a new press is accepted.
- `multi`  out  1  — high if the accepted key pattern had more than one bit set. Updated together with `bcd`.
- `held`  out  1  — high while an accepted key is still down, or its release is still being debounced.

## Operation
- **Synchronizer:** two-flop chain on all 10 bits, `key` → `s1` → `ks`. The FSM sees only `ks`.
- **Registers:** 10-bit candidate `cand`, 8-bit counter `cnt`.
- **FSM states and transitions:**
  - **IDLE**
    - `ks`==0 → stay.
    - `ks`!=0 → load `cand`=`ks`, `cnt`=0, go to DEBOUNCE.
  - **DEBOUNCE**
    - `ks`==0 → IDLE.
    - `ks`!=0 and `ks`!=`cand` → reload `cand`=`ks`, `cnt`=0, stay.
    - `ks`==`cand` and `cnt`==`DEBOUNCE_CYCLES`-1 → go to HELD. On that edge, register `bcd`=encode(`cand`), `multi`=(popcount(`cand`)>1), `valid`=1.
    - Otherwise → `cnt`+1.
  - **HELD**
    - `ks`!=0 → stay. A change of pattern while held is ignored: no new `valid`, `bcd` unchanged.
    - `ks`==0 → `cnt`=0, go to RELEASE.
  - **RELEASE**
    - `ks`!=0 → back to HELD, no `valid`. This treats release bounce as the same press.
    - `ks`==0 and `cnt`==`DEBOUNCE_CYCLES`-1 → IDLE.
    - Otherwise → `cnt`+1.
- **Encoding rule:** `bcd` = index of the highest set bit of `cand`. With 10 inputs the result is always 0–9, never 10–15.
- **Outputs:**
  - `valid` is registered and deasserts on the next edge.
  - `held` = state is HELD or RELEASE, registered.
- **Simultaneous keys:** the highest digit wins and `multi`=1. A new lone press clears `multi` when it is accepted.
- **Reset values:** `bcd`=0, `valid`=0, `multi`=0, `held`=0, state IDLE, `cnt`=0, `cand`=0, `s1`=`ks`=0.
- **Reset mid-operation:**
  - Any state returns to IDLE immediately, with no `valid` pulse.
  - A key still down when `rst` falls is debounced from scratch and yields exactly one `valid`.

## Timing
- Let `key` be stable before rising edge k. Then `ks` updates at k+1, DEBOUNCE is entered at k+2, and `valid` plus the new `bcd`/`multi` appear at k+2+`DEBOUNCE_CYCLES`. For D=4 that is edge k+6.
- `valid` is high for exactly one cycle per accepted press. `bcd` is stable from that edge until the next accepted press.
- Release latency:
  - `held` falls at edge r+2+`DEBOUNCE_CYCLES`, where r is the first edge with `key`==0 stable.
  - A new press is then debounced from IDLE.
- Glitch handling:
  - A `ks` glitch shorter than `DEBOUNCE_CYCLES` during DEBOUNCE produces no `valid`.
  - The same glitch during RELEASE keeps the block in HELD.
- With `DEBOUNCE_CYCLES`=1, the first matching compare accepts, giving `valid` at edge k+3.
- No combinational path from `key` to any output.

## Test plan
1. **Single press:** reset, then `key`=10'b00_0000_1000 held for 20 cycles, D=4. Expect `valid` for exactly one cycle at k+6, `bcd`=3, `multi`=0, and `held`=1 until 6 cycles after release.
2. **Multi-key:** `key`=bits 2 and 7 together. Expect `bcd`=7, `multi`=1, one `valid`. A following lone press of digit 0 gives `bcd`=0, `multi`=0.
3. **Press bounce:** toggle bit 5 every 2 cycles for 10 cycles, then hold. Expect no `valid` during bouncing, then exactly one `valid` with `bcd`=5.
4. **Release bounce:** while digit 9 is held, drop `key` to 0 for 2 cycles, restore it for 3 cycles, then release. Expect no second `valid`, `held` stays 1 through the bounce, `bcd`=9 throughout.
5. **Reset mid-operation:** assert `rst` while in DEBOUNCE with digit 4 down, and keep `key` asserted. Expect all outputs 0 during reset, then one `valid` with `bcd`=4 at 2+D edges after `rst` falls.
6. **Exhaustive digits:** press each digit 0–9 in sequence, each held long enough and fully released in between. Expect 10 `valid` pulses with `bcd`=0..9 in order and `multi` always 0.
